// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master arbiter in front of one single-beat memory
//               command/response bus. Reads are tagged in an in-order FIFO
//               so each response strobe is steered back to its issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_PENDING = 4,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,

    // master 0 (CPU bus wrapper)
    input  logic                         m0_cmd_valid,
    output logic                         m0_cmd_ready,
    input  logic                         m0_cmd_wr,
    input  logic [31:0]                  m0_cmd_addr,
    input  logic [31:0]                  m0_cmd_wdata,
    input  logic [3:0]                   m0_cmd_be,
    output logic                         m0_rsp_ready,
    output logic [31:0]                  m0_rsp_rdata,

    // master 1 (DMA / video fetch)
    input  logic                         m1_cmd_valid,
    output logic                         m1_cmd_ready,
    input  logic                         m1_cmd_wr,
    input  logic [31:0]                  m1_cmd_addr,
    input  logic [31:0]                  m1_cmd_wdata,
    input  logic [3:0]                   m1_cmd_be,
    output logic                         m1_rsp_ready,
    output logic [31:0]                  m1_rsp_rdata,

    // slave side
    output logic                         s_cmd_valid,
    input  logic                         s_cmd_ready,
    output logic                         s_cmd_wr,
    output logic [31:0]                  s_cmd_addr,
    output logic [31:0]                  s_cmd_wdata,
    output logic [3:0]                   s_cmd_be,
    input  logic                         s_rsp_ready,
    input  logic [31:0]                  s_rsp_rdata,

    // status
    output logic [$clog2(MAX_PENDING):0] pending_cnt,
    output logic                         rsp_orphan
);

    // Pointer width covers MAX_PENDING slots exactly; with a power-of-two
    // depth the pointers wrap naturally on overflow.
    localparam int                   c_PTR_W   = $clog2(MAX_PENDING);
    localparam int                   c_CNT_W   = $clog2(MAX_PENDING) + 1;
    localparam logic [c_CNT_W-1:0]   c_MAX_CNT = c_CNT_W'(MAX_PENDING);
    localparam logic [c_CNT_W-1:0]   c_ZERO    = '0;
    localparam logic [c_CNT_W-1:0]   c_ONE     = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                     r_rrLast;      // last master granted
    logic                     r_lockVld;     // grant pinned to a stalled command
    logic                     r_lockId;
    logic [MAX_PENDING-1:0]   r_tagFifo;     // master id per outstanding read
    logic [c_PTR_W-1:0]       r_rdPtr;
    logic [c_PTR_W-1:0]       r_wrPtr;
    logic [c_CNT_W-1:0]       r_pendingCnt;
    logic                     r_rspOrphan;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                     w_grant;
    logic                     w_grantValid;
    logic                     w_grantWr;
    logic                     w_canIssue;
    logic                     w_cmdValid;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_headId;
    logic                     w_hasPending;

    assign w_hasPending = (r_pendingCnt != c_ZERO);
    assign w_headId     = r_tagFifo[r_rdPtr];

    // Grant selection: a stalled command keeps the bus, otherwise the
    // single requester wins, and contention goes to priority or round-robin.
    always_comb begin
        w_grant = 1'b0;
        if (r_lockVld) begin
            w_grant = r_lockId;
        end else if (m0_cmd_valid && m1_cmd_valid) begin
            w_grant = FIXED_PRIO ? 1'b0 : ~r_rrLast;
        end else if (m1_cmd_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
    end

    // Payload mux of the granted master; master 0 is the idle default.
    always_comb begin
        w_grantValid = m0_cmd_valid;
        w_grantWr    = m0_cmd_wr;
        s_cmd_wr     = m0_cmd_wr;
        s_cmd_addr   = m0_cmd_addr;
        s_cmd_wdata  = m0_cmd_wdata;
        s_cmd_be     = m0_cmd_be;
        if (w_grant) begin
            w_grantValid = m1_cmd_valid;
            w_grantWr    = m1_cmd_wr;
            s_cmd_wr     = m1_cmd_wr;
            s_cmd_addr   = m1_cmd_addr;
            s_cmd_wdata  = m1_cmd_wdata;
            s_cmd_be     = m1_cmd_be;
        end
    end

    // A read may only issue if a tag slot is free now, or one is being
    // freed by a response in this same cycle. Writes never need a slot.
    always_comb begin
        w_canIssue = w_grantWr
                  || (r_pendingCnt < c_MAX_CNT)
                  || ((r_pendingCnt == c_MAX_CNT) && s_rsp_ready);
    end

    // Handshake and FIFO strobes, all suppressed while reset is held.
    always_comb begin
        w_cmdValid = !reset && w_grantValid && w_canIssue;
        w_accept   = w_cmdValid && s_cmd_ready;
        w_push     = w_accept && !w_grantWr;
        w_pop      = !reset && s_rsp_ready && w_hasPending;
    end

    // Output steering for command readies and response strobes.
    always_comb begin
        s_cmd_valid  = w_cmdValid;
        m0_cmd_ready = w_accept && !w_grant;
        m1_cmd_ready = w_accept &&  w_grant;
        m0_rsp_ready = w_pop && !w_headId;
        m1_rsp_ready = w_pop &&  w_headId;
        m0_rsp_rdata = s_rsp_rdata;
        m1_rsp_rdata = s_rsp_rdata;
        pending_cnt  = r_pendingCnt;
        rsp_orphan   = r_rspOrphan;
    end

    // Arbitration history and stall lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rrLast  <= 1'b1;
            r_lockVld <= 1'b0;
            r_lockId  <= 1'b0;
        end else if (w_accept) begin
            r_rrLast  <= w_grant;
            r_lockVld <= 1'b0;
        end else if (w_cmdValid) begin
            r_lockVld <= 1'b1;
            r_lockId  <= w_grant;
        end
    end

    // Tag FIFO storage and pointers. On a full-FIFO push+pop the write
    // lands in the slot whose head is being consumed this same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tagFifo <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
        end else begin
            if (w_push) begin
                r_tagFifo[r_wrPtr] <= w_grant;
                r_wrPtr            <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
        end
    end

    // Outstanding read counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pendingCnt <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_pendingCnt <= r_pendingCnt + c_ONE;
                2'b01:   r_pendingCnt <= r_pendingCnt - c_ONE;
                default: r_pendingCnt <= r_pendingCnt;
            endcase
        end
    end

    // Sticky flag for a response strobe with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rspOrphan <= 1'b0;
        end else if (s_rsp_ready && !w_hasPending) begin
            r_rspOrphan <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (round-robin
//               instance plus a fixed-priority instance).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // round-robin instance
    logic        m0_cmd_valid, m0_cmd_wr, m0_cmd_ready, m0_rsp_ready;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata, m0_rsp_rdata;
    logic [3:0]  m0_cmd_be;
    logic        m1_cmd_valid, m1_cmd_wr, m1_cmd_ready, m1_rsp_ready;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata, m1_rsp_rdata;
    logic [3:0]  m1_cmd_be;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_wr, s_rsp_ready;
    logic [31:0] s_cmd_addr, s_cmd_wdata, s_rsp_rdata;
    logic [3:0]  s_cmd_be;
    logic [2:0]  pending_cnt;
    logic        rsp_orphan;

    // fixed-priority instance
    logic        f0_valid, f1_valid, f0_ready, f1_ready, f0_rspRdy, f1_rspRdy;
    logic [31:0] f0_rdata, f1_rdata;
    logic        fs_valid, fs_wr;
    logic [31:0] fs_addr, fs_wdata;
    logic [3:0]  fs_be;
    logic [2:0]  f_pending;
    logic        f_orphan;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_PENDING(4), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
        .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_be(m0_cmd_be),
        .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
        .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_be(m1_cmd_be),
        .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
        .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_be(s_cmd_be),
        .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .pending_cnt(pending_cnt), .rsp_orphan(rsp_orphan)
    );

    mem_arbiter #(.MAX_PENDING(4), .FIXED_PRIO(1'b1)) dutFixed (
        .clk(clk), .reset(reset),
        .m0_cmd_valid(f0_valid), .m0_cmd_ready(f0_ready), .m0_cmd_wr(1'b1),
        .m0_cmd_addr(32'hA0), .m0_cmd_wdata(32'h0), .m0_cmd_be(4'hF),
        .m0_rsp_ready(f0_rspRdy), .m0_rsp_rdata(f0_rdata),
        .m1_cmd_valid(f1_valid), .m1_cmd_ready(f1_ready), .m1_cmd_wr(1'b1),
        .m1_cmd_addr(32'hB0), .m1_cmd_wdata(32'h1), .m1_cmd_be(4'hF),
        .m1_rsp_ready(f1_rspRdy), .m1_rsp_rdata(f1_rdata),
        .s_cmd_valid(fs_valid), .s_cmd_ready(1'b1), .s_cmd_wr(fs_wr),
        .s_cmd_addr(fs_addr), .s_cmd_wdata(fs_wdata), .s_cmd_be(fs_be),
        .s_rsp_ready(1'b0), .s_rsp_rdata(32'h0),
        .pending_cnt(f_pending), .rsp_orphan(f_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are then driven 1 ns after the edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        m0_cmd_valid = 0; m0_cmd_wr = 0; m0_cmd_addr = 0; m0_cmd_wdata = 0; m0_cmd_be = 4'hF;
        m1_cmd_valid = 0; m1_cmd_wr = 0; m1_cmd_addr = 0; m1_cmd_wdata = 0; m1_cmd_be = 4'hF;
        s_cmd_ready = 1; s_rsp_ready = 0; s_rsp_rdata = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idleInputs();
        f0_valid = 0; f1_valid = 0;
        reset = 1;

        // ---------------- reset gating and reset state ----------------
        m0_cmd_valid = 1; m0_cmd_addr = 32'h40; s_rsp_ready = 1;
        #2;
        chk("rst_s_cmd_valid", s_cmd_valid, 0);
        chk("rst_m0_cmd_ready", m0_cmd_ready, 0);
        chk("rst_m0_rsp_ready", m0_rsp_ready, 0);
        nextCycle();
        nextCycle();
        reset = 0;
        idleInputs();
        #1;
        chk("rst_pending", pending_cnt, 0);
        chk("rst_orphan", rsp_orphan, 0);
        nextCycle();

        // ---------------- round-robin continuous reads ----------------
        for (int k = 0; k < 8; k++) begin
            m0_cmd_valid = 1; m0_cmd_addr = 32'h100;
            m1_cmd_valid = 1; m1_cmd_addr = 32'h200;
            s_rsp_ready  = (k >= 2);
            s_rsp_rdata  = (k < 2) ? 32'h0 : (((k - 2) % 2) != 0 ? 32'h200 : 32'h100);
            #1;
            chk("rr_s_addr", s_cmd_addr, (k % 2) != 0 ? 32'h200 : 32'h100);
            chk("rr_m0_cmd_ready", m0_cmd_ready, (k % 2) == 0);
            chk("rr_m1_cmd_ready", m1_cmd_ready, (k % 2) != 0);
            chk("rr_pending", pending_cnt, (k < 2) ? k : 2);
            chk("rr_m0_rsp_ready", m0_rsp_ready, (k >= 2) && ((k - 2) % 2) == 0);
            chk("rr_m1_rsp_ready", m1_rsp_ready, (k >= 2) && ((k - 2) % 2) != 0);
            if (k >= 2)
                chk("rr_rdata", ((k - 2) % 2) != 0 ? m1_rsp_rdata : m0_rsp_rdata,
                    ((k - 2) % 2) != 0 ? 32'h200 : 32'h100);
            nextCycle();
        end
        idleInputs();
        s_rsp_ready = 1; s_rsp_rdata = 32'h100;
        #1;
        chk("rr_drain0_m0", m0_rsp_ready, 1);
        chk("rr_drain0_pending", pending_cnt, 2);
        nextCycle();
        s_rsp_rdata = 32'h200;
        #1;
        chk("rr_drain1_m1", m1_rsp_ready, 1);
        chk("rr_drain1_m0", m0_rsp_ready, 0);
        nextCycle();
        s_rsp_ready = 0;
        #1;
        chk("rr_drained", pending_cnt, 0);

        // ---------------- stalled m1 read keeps the grant ----------------
        m1_cmd_valid = 1; m1_cmd_addr = 32'h300; s_cmd_ready = 0;
        #1;
        chk("stall0_s_valid", s_cmd_valid, 1);
        chk("stall0_addr", s_cmd_addr, 32'h300);
        chk("stall0_m1_ready", m1_cmd_ready, 0);
        nextCycle();
        m0_cmd_valid = 1; m0_cmd_addr = 32'h400;
        #1;
        chk("stall1_addr", s_cmd_addr, 32'h300);
        chk("stall1_m0_ready", m0_cmd_ready, 0);
        nextCycle();
        #1;
        chk("stall2_addr", s_cmd_addr, 32'h300);
        nextCycle();
        s_cmd_ready = 1;
        #1;
        chk("stall_m1_accept", m1_cmd_ready, 1);
        chk("stall_m0_wait", m0_cmd_ready, 0);
        chk("stall_accept_addr", s_cmd_addr, 32'h300);
        nextCycle();
        m1_cmd_valid = 0;
        #1;
        chk("stall_m0_accept", m0_cmd_ready, 1);
        chk("stall_m0_addr", s_cmd_addr, 32'h400);
        nextCycle();
        m0_cmd_valid = 0; s_rsp_ready = 1; s_rsp_rdata = 32'h300;
        #1;
        chk("stall_rsp_m1", m1_rsp_ready, 1);
        chk("stall_rsp_m0", m0_rsp_ready, 0);
        chk("stall_pending", pending_cnt, 2);
        nextCycle();
        s_rsp_rdata = 32'h400;
        #1;
        chk("stall_rsp2_m0", m0_rsp_ready, 1);
        nextCycle();
        s_rsp_ready = 0;
        #1;
        chk("stall_drained", pending_cnt, 0);

        // ---------------- full tag FIFO ----------------
        for (int i = 0; i < 4; i++) begin
            m0_cmd_valid = 1; m0_cmd_addr = 32'h10 + i;
            #1;
            chk("fill_m0_ready", m0_cmd_ready, 1);
            nextCycle();
        end
        m0_cmd_addr = 32'h500;
        #1;
        chk("full_pending", pending_cnt, 4);
        chk("full_no_issue", s_cmd_valid, 0);
        chk("full_m0_ready", m0_cmd_ready, 0);
        nextCycle();
        m1_cmd_valid = 1; m1_cmd_wr = 1; m1_cmd_addr = 32'h600; m1_cmd_wdata = 32'hDEAD;
        #1;
        chk("full_wr_m1_ready", m1_cmd_ready, 1);
        chk("full_wr_m0_ready", m0_cmd_ready, 0);
        chk("full_wr_s_wr", s_cmd_wr, 1);
        chk("full_wr_wdata", s_cmd_wdata, 32'hDEAD);
        nextCycle();
        m1_cmd_valid = 0; m1_cmd_wr = 0;
        s_rsp_ready = 1; s_rsp_rdata = 32'hAA;
        #1;
        chk("full_swap_pending_before", pending_cnt, 4);
        chk("full_swap_s_valid", s_cmd_valid, 1);
        chk("full_swap_m0_cmd", m0_cmd_ready, 1);
        chk("full_swap_m0_rsp", m0_rsp_ready, 1);
        nextCycle();
        m0_cmd_valid = 0;
        #1;
        chk("full_swap_pending_after", pending_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_drain_m0", m0_rsp_ready, 1);
            nextCycle();
        end
        s_rsp_ready = 0;
        #1;
        chk("full_drained", pending_cnt, 0);

        // ---------------- orphan response ----------------
        s_rsp_ready = 1;
        #1;
        chk("orph_m0_rsp", m0_rsp_ready, 0);
        chk("orph_m1_rsp", m1_rsp_ready, 0);
        nextCycle();
        s_rsp_ready = 0;
        #1;
        chk("orph_set", rsp_orphan, 1);
        nextCycle();
        nextCycle();
        chk("orph_sticky", rsp_orphan, 1);

        // ---------------- reset with reads pending ----------------
        for (int i = 0; i < 3; i++) begin
            m0_cmd_valid = 1; m0_cmd_addr = 32'h700 + i;
            nextCycle();
        end
        m0_cmd_valid = 0;
        #1;
        chk("pre_rst_pending", pending_cnt, 3);
        reset = 1;
        m0_cmd_valid = 1; m1_cmd_valid = 1; s_rsp_ready = 1;
        #1;
        chk("mid_rst_s_valid", s_cmd_valid, 0);
        chk("mid_rst_m0_cmd", m0_cmd_ready, 0);
        chk("mid_rst_m1_cmd", m1_cmd_ready, 0);
        chk("mid_rst_m0_rsp", m0_rsp_ready, 0);
        nextCycle();
        reset = 0;
        idleInputs();
        #1;
        chk("post_rst_pending", pending_cnt, 0);
        chk("post_rst_orphan", rsp_orphan, 0);
        s_rsp_ready = 1;
        #1;
        chk("post_rst_rsp_m0", m0_rsp_ready, 0);
        nextCycle();
        s_rsp_ready = 0;
        m0_cmd_valid = 1; m0_cmd_addr = 32'h800;
        m1_cmd_valid = 1; m1_cmd_addr = 32'h900;
        #1;
        chk("post_rst_orphan_set", rsp_orphan, 1);
        chk("post_rst_m0_wins", m0_cmd_ready, 1);
        chk("post_rst_m1_waits", m1_cmd_ready, 0);
        nextCycle();
        m0_cmd_valid = 0; m1_cmd_valid = 0;
        s_rsp_ready = 1; s_rsp_rdata = 32'h800;
        #1;
        chk("post_rst_rsp_head_m0", m0_rsp_ready, 1);
        chk("post_rst_rsp_head_m1", m1_rsp_ready, 0);
        nextCycle();
        s_rsp_ready = 0;
        #1;
        chk("post_rst_drained", pending_cnt, 0);

        // ---------------- fixed priority instance ----------------
        f0_valid = 1; f1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fp_m0_ready", f0_ready, 1);
            chk("fp_m1_ready", f1_ready, 0);
            nextCycle();
        end
        f0_valid = 0;
        #1;
        chk("fp_m1_after", f1_ready, 1);
        chk("fp_m1_addr", fs_addr, 32'hB0);
        nextCycle();
        f1_valid = 0;
        nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
